product_checker: RTL and testbench

Consumer end of the multiplier test-stimulus interface. Accepts `input_set`/`a`/`b` vectors from the stimulus generator and launches each vector into the multiplier under test. Computes the reference product with an internal WIDTH-cycle shift-add engine and compares the two results. On the first mismatch it freezes and reports the failing operands; if the sweep completes cleanly it reports pass.

---
 rtl/product_checker.sv | 226 ++++++++++++++++++++++
 tb/tb_product_checker.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/product_checker.sv
// product_checker: consumer end of the multiplier test-stimulus interface.
// Launches each input vector into the multiplier under test, computes the
// reference product with a WIDTH-cycle shift-add engine, and compares them.
// Freezes in FAIL on the first mismatch; reports pass once the sweep ends.
//
// Optional feature: define PRODUCT_CHECKER_TIMEOUT_EN to fail a vector whose
// dut_done has not arrived TIMEOUT cycles after dut_start. Without it, RUN
// waits for dut_done indefinitely and no counter exists.
//
// Handshake: input_set and dut_done are single-cycle strobes with no
// back-pressure; their data (a/b, dut_product) is valid only in that cycle.
// dut_start is a one-cycle pulse; dut_a/dut_b stay stable while busy.
// fsm_state exposes the controller state for debug and checkers.
module product_checker #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 input_set,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sweep_done,
    output logic                 dut_start,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    input  logic                 dut_done,
    input  logic [2*WIDTH-1:0]   dut_product,
    output logic                 busy,
    output logic                 error,
    output logic [WIDTH-1:0]     err_a,
    output logic [WIDTH-1:0]     err_b,
    output logic [2*WIDTH-1:0]   err_expected,
    output logic [2*WIDTH-1:0]   err_actual,
    output logic                 overrun,
    output logic                 pass,
    output logic [31:0]          check_count,
    output logic [2:0]           fsm_state
);

    localparam int ITER_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH - 1);

    // Reject configurations the engine and timeout logic cannot handle.
    if (WIDTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("product_checker: WIDTH must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_COMPARE = 3'd2,
        S_FAIL    = 3'd3,
        S_PASS    = 3'd4
    } state_t;

    state_t               state;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [ITER_W-1:0]    iter;
    logic                 ref_done;
    logic [2*WIDTH-1:0]   dut_hold;
    logic                 dut_seen;
    logic                 sweep_seen;

    logic [2*WIDTH-1:0]   step_acc;
    logic [2*WIDTH-1:0]   next_acc;
    logic                 next_ref_done;
    logic                 next_dut_seen;

`ifdef PRODUCT_CHECKER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0]     tmo_cnt;
    logic                 timed_out;
    // Counter saturates at its last value, so the timeout stays pending
    // until the reference engine has produced the expected value.
    assign timed_out = (tmo_cnt == TMO_LAST);
`endif

    assign fsm_state = state;

    // Look-ahead of this cycle's engine step and result capture, so RUN can
    // leave in the same cycle that the last condition becomes true.
    always_comb begin
        step_acc      = mplier[0] ? (acc + mcand) : acc;
        next_acc      = ref_done ? acc : step_acc;
        next_ref_done = ref_done | (iter == ITER_LAST);
        next_dut_seen = dut_seen | dut_done;
    end

    // Controller, reference engine and all registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_IDLE;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            iter         <= '0;
            ref_done     <= 1'b0;
            dut_hold     <= '0;
            dut_seen     <= 1'b0;
            sweep_seen   <= 1'b0;
            dut_start    <= 1'b0;
            dut_a        <= '0;
            dut_b        <= '0;
            busy         <= 1'b0;
            error        <= 1'b0;
            err_a        <= '0;
            err_b        <= '0;
            err_expected <= '0;
            err_actual   <= '0;
            overrun      <= 1'b0;
            pass         <= 1'b0;
            check_count  <= '0;
`ifdef PRODUCT_CHECKER_TIMEOUT_EN
            tmo_cnt      <= '0;
`endif
        end else begin
            dut_start <= 1'b0;
            if (sweep_done) begin
                sweep_seen <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (input_set) begin
                        dut_a     <= a;
                        dut_b     <= b;
                        dut_start <= 1'b1;
                        busy      <= 1'b1;
                        acc       <= '0;
                        mcand     <= {{WIDTH{1'b0}}, a};
                        mplier    <= b;
                        iter      <= '0;
                        ref_done  <= 1'b0;
                        dut_hold  <= '0;
                        dut_seen  <= 1'b0;
`ifdef PRODUCT_CHECKER_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                        state     <= S_RUN;
                    end else if (sweep_done || sweep_seen) begin
                        pass  <= 1'b1;
                        state <= S_PASS;
                    end
                end

                S_RUN: begin
                    if (input_set) begin
                        overrun <= 1'b1;
                    end
                    if (!ref_done) begin
                        acc    <= step_acc;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        iter   <= iter + ITER_W'(1);
                        if (iter == ITER_LAST) begin
                            ref_done <= 1'b1;
                        end
                    end
                    // Only the first dut_done of a vector is kept.
                    if (!dut_seen && dut_done) begin
                        dut_hold <= dut_product;
                        dut_seen <= 1'b1;
                    end
`ifdef PRODUCT_CHECKER_TIMEOUT_EN
                    if (tmo_cnt != TMO_LAST) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
`endif
                    if (next_ref_done && next_dut_seen) begin
                        state <= S_COMPARE;
                    end
`ifdef PRODUCT_CHECKER_TIMEOUT_EN
                    else if (next_ref_done && timed_out) begin
                        error        <= 1'b1;
                        err_a        <= dut_a;
                        err_b        <= dut_b;
                        err_expected <= next_acc;
                        err_actual   <= '0;
                        busy         <= 1'b0;
                        state        <= S_FAIL;
                    end
`endif
                end

                S_COMPARE: begin
                    if (input_set) begin
                        overrun <= 1'b1;
                    end
                    busy <= 1'b0;
                    if (acc == dut_hold) begin
                        if (check_count != '1) begin
                            check_count <= check_count + 32'd1;
                        end
                        if (sweep_seen || sweep_done) begin
                            pass  <= 1'b1;
                            state <= S_PASS;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        error        <= 1'b1;
                        err_a        <= dut_a;
                        err_b        <= dut_b;
                        err_expected <= acc;
                        err_actual   <= dut_hold;
                        state        <= S_FAIL;
                    end
                end

                // Terminal until reset; strobes are ignored here.
                S_FAIL, S_PASS: begin
                    state <= state;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_checker.sv
// tb_product_checker: directed scoreboard bench for product_checker.
// Drivers push the expected completion record for each vector; a monitor
// pops and compares whenever busy falls. A behavioural multiplier model
// answers dut_start with a configurable latency, corruption or silence.
module tb_product_checker;

    localparam int W   = 16;
    localparam int TMO = 64;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           input_set = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           sweep_done = 1'b0;
    logic           dut_start;
    logic [W-1:0]   dut_a;
    logic [W-1:0]   dut_b;
    logic           dut_done = 1'b0;
    logic [2*W-1:0] dut_product = '0;
    logic           busy;
    logic           error;
    logic [W-1:0]   err_a;
    logic [W-1:0]   err_b;
    logic [2*W-1:0] err_expected;
    logic [2*W-1:0] err_actual;
    logic           overrun;
    logic           pass;
    logic [31:0]    check_count;
    logic [2:0]     fsm_state;

    product_checker #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .input_set(input_set), .a(a), .b(b),
        .sweep_done(sweep_done), .dut_start(dut_start), .dut_a(dut_a),
        .dut_b(dut_b), .dut_done(dut_done), .dut_product(dut_product),
        .busy(busy), .error(error), .err_a(err_a), .err_b(err_b),
        .err_expected(err_expected), .err_actual(err_actual),
        .overrun(overrun), .pass(pass), .check_count(check_count),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int             cycle;
        logic           err;
        logic [31:0]    cnt;
        logic           pas;
        logic [W-1:0]   ea;
        logic [W-1:0]   eb;
        logic [2*W-1:0] ee;
        logic [2*W-1:0] ex;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- multiplier-under-test model ----------------
    int   model_delay   = 3;
    logic model_corrupt = 1'b0;
    logic model_silent  = 1'b0;

    initial begin : mult_model
        logic           pend;
        int             cnt;
        logic [W-1:0]   pa;
        logic [W-1:0]   pb;
        logic [2*W-1:0] p;
        pend = 1'b0;
        cnt  = 0;
        pa   = '0;
        pb   = '0;
        forever begin
            @(posedge clock);
            #1;
            dut_done = 1'b0;
            if (dut_start) begin
                pend = 1'b1;
                cnt  = model_delay;
                pa   = dut_a;
                pb   = dut_b;
            end
            if (pend && !model_silent) begin
                if (cnt == 0) begin
                    p = {{W{1'b0}}, pa} * {{W{1'b0}}, pb};
                    if (model_corrupt) p = p ^ 1;
                    dut_product = p;
                    dut_done    = 1'b1;
                    pend        = 1'b0;
                end else begin
                    cnt--;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_busy  = 1'b0;
    logic prev_reset = 1'b1;

    always @(negedge clock) begin : monitor
        exp_t e;
        if (prev_busy && !busy && !prev_reset) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion (cycle %0d): got a completion, expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle",   cyc,          e.cycle);
                check("error",        error,        e.err);
                check("check_count",  check_count,  e.cnt);
                check("pass",         pass,         e.pas);
                check("err_a",        err_a,        e.ea);
                check("err_b",        err_b,        e.eb);
                check("err_expected", err_expected, e.ee);
                check("err_actual",   err_actual,   e.ex);
            end
        end
        prev_busy  = busy;
        prev_reset = reset;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called at the start of cycle N; returns N and leaves time in cycle N+1.
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, output int n);
        input_set = 1'b1;
        a         = va;
        b         = vb;
        n         = cyc;
        step(1);
        input_set = 1'b0;
    endtask

    // Busy falls the cycle after COMPARE; COMPARE is the later of the
    // engine finishing (N+W+1) and the cycle after dut_done (N+1+d+1).
    function automatic int fall_cycle(input int n, input int d);
        int c;
        c = n + W + 1;
        if (n + d + 2 > c) c = n + d + 2;
        return c + 1;
    endfunction

    task automatic push_rec(input int cy, input logic er, input logic [31:0] cnt, input logic ps,
                            input logic [W-1:0] ea, input logic [W-1:0] eb,
                            input logic [2*W-1:0] ee, input logic [2*W-1:0] ex);
        exp_t e;
        e.cycle = cy; e.err = er; e.cnt = cnt; e.pas = ps;
        e.ea = ea; e.eb = eb; e.ee = ee; e.ex = ex;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 200) begin
            step(1);
            k++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle (cycle %0d): busy still 1 after %0d cycles, expected 0", cyc, k);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},         busy,         0);
        check({tag, "_dut_start"},    dut_start,    0);
        check({tag, "_dut_a"},        dut_a,        0);
        check({tag, "_dut_b"},        dut_b,        0);
        check({tag, "_error"},        error,        0);
        check({tag, "_err_a"},        err_a,        0);
        check({tag, "_err_b"},        err_b,        0);
        check({tag, "_err_expected"}, err_expected, 0);
        check({tag, "_err_actual"},   err_actual,   0);
        check({tag, "_overrun"},      overrun,      0);
        check({tag, "_pass"},         pass,         0);
        check({tag, "_check_count"},  check_count,  0);
        check({tag, "_fsm_state"},    fsm_state,    0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        check_all_zero("reset");
        reset = 1'b0;
        step(1);
    endtask

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stimulus
        int n;
        step(1);
        do_reset();

        // Correct model, three vectors back to back, then end of sweep.
        model_delay = 3;
        send(16'd3, 16'd5, n);
        push_rec(fall_cycle(n, 3), 0, 1, 0, 0, 0, 0, 0);
        wait_idle();
        send(16'hFFFF, 16'hFFFF, n);
        push_rec(fall_cycle(n, 3), 0, 2, 0, 0, 0, 0, 0);
        wait_idle();
        send(16'h0000, 16'h1234, n);
        push_rec(fall_cycle(n, 3), 0, 3, 0, 0, 0, 0, 0);
        wait_idle();
        sweep_done = 1'b1;
        step(1);
        sweep_done = 1'b0;
        check("sweep_pass", pass, 1);
        check("sweep_state", fsm_state, 4);
        check("sweep_count", check_count, 3);
        check("sweep_error", error, 0);
        input_set = 1'b1; a = 16'd1; b = 16'd1;
        step(1);
        input_set = 1'b0;
        check("pass_ignore_overrun", overrun, 0);
        check("pass_ignore_start", dut_start, 0);
        check("pass_ignore_busy", busy, 0);

        // dut_done together with dut_start, then an overrun, then a slow
        // response with sweep_done arriving mid-flight.
        do_reset();
        model_delay = 0;
        send(16'd5, 16'd6, n);
        push_rec(fall_cycle(n, 0), 0, 1, 0, 0, 0, 0, 0);
        wait_idle();
        send(16'h8000, 16'd2, n);
        push_rec(fall_cycle(n, 0), 0, 2, 0, 0, 0, 0, 0);
        wait_idle();

        model_delay = 3;
        send(16'd11, 16'd13, n);
        push_rec(fall_cycle(n, 3), 0, 3, 0, 0, 0, 0, 0);
        step(4);
        input_set = 1'b1; a = 16'd1; b = 16'd1;
        step(1);
        input_set = 1'b0;
        check("overrun_flag", overrun, 1);
        check("overrun_dut_a", dut_a, 11);
        check("overrun_dut_b", dut_b, 13);
        check("overrun_busy", busy, 1);
        wait_idle();

        model_delay = 40;
        send(16'd2, 16'd2, n);
        push_rec(fall_cycle(n, 40), 0, 4, 1, 0, 0, 0, 0);
        step(10);
        sweep_done = 1'b1;
        step(1);
        sweep_done = 1'b0;
        check("late_sweep_busy", busy, 1);
        wait_idle();
        check("late_sweep_state", fsm_state, 4);

        // Reset in the 8th RUN cycle aborts; a fresh vector then checks.
        do_reset();
        model_delay = 3;
        send(16'd4, 16'd4, n);
        push_rec(fall_cycle(n, 3), 0, 1, 0, 0, 0, 0, 0);
        wait_idle();
        send(16'd9, 16'd9, n);
        step(7);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check_all_zero("mid_reset");
        send(16'd4, 16'd4, n);
        push_rec(fall_cycle(n, 3), 0, 1, 0, 0, 0, 0, 0);
        wait_idle();

        // Corrupted product: first failure is frozen, pass never rises.
        model_corrupt = 1'b1;
        send(16'd7, 16'd9, n);
        push_rec(fall_cycle(n, 3), 1, 1, 0, 16'd7, 16'd9, 32'd63, 32'd62);
        wait_idle();
        model_corrupt = 1'b0;
        sweep_done = 1'b1;
        step(1);
        sweep_done = 1'b0;
        step(1);
        check("fail_pass", pass, 0);
        check("fail_state", fsm_state, 3);
        check("fail_error", error, 1);
        input_set = 1'b1; a = 16'd1; b = 16'd1;
        step(1);
        input_set = 1'b0;
        check("fail_ignore_overrun", overrun, 0);
        check("fail_ignore_dut_a", dut_a, 7);

`ifdef PRODUCT_CHECKER_TIMEOUT_EN
        // Silent multiplier: fails TIMEOUT cycles after dut_start.
        do_reset();
        model_silent = 1'b1;
        send(16'd6, 16'd7, n);
        push_rec(n + TMO + 1, 1, 0, 0, 16'd6, 16'd7, 32'd42, 32'd0);
        wait_idle();
        model_silent = 1'b0;
        check("timeout_state", fsm_state, 3);
`endif

        step(3);
        check("queue_empty", exp_q.size(), 0);
        summary();
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog (cycle %0d): simulation still running, expected completion", cyc);
        summary();
        $fatal(1, "watchdog expired");
    end

endmodule
